// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiplier that takes WIDTH cycles regardless of operand values.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             valid_o
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] step_sum;
  logic             slt;

  // Single-cycle opcode results (MUL is handled by the iterative datapath)
  always_comb begin
    slt     = ($signed(data1_i) < $signed(data2_i));
    alu_res = '0;
    case (ALUCtrl_i)
      3'b010:  alu_res = data1_i + data2_i;
      3'b110:  alu_res = data1_i - data2_i;
      3'b000:  alu_res = data1_i & data2_i;
      3'b001:  alu_res = data1_i | data2_i;
      3'b111:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: accumulate the shifted multiplicand when multiplier LSB is set
  always_comb begin
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == 3'b011) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = MUL;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // The final step's sum goes straight to the result register
        if (cnt_q == CNT_W'(1)) begin
          data_d  = step_sum;
          zero_d  = (step_sum == '0);
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign data_o  = data_q;
  assign Zero_o  = zero_q;
  assign valid_o = valid_q;

endmodule
